char_buffer_ctrl: RTL

Write-side controller for the 80x24 character buffer. It accepts terminal-level commands from the host side: write a character at the cursor, clear the screen, erase to end of line, and newline. Each command becomes a sequence of single-byte writes on the buffer write port, with cursor tracking, line wrap and hardware scrolling. Scrolling uses a rotating top-row offset (`first_row`) that the video fetch path adds to its row count; on scroll, only the newly exposed line is cleared, and no buffer contents are copied.

---
 rtl/char_buffer_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl: turns terminal commands (write, clear, erase-EOL, newline) into
// single-byte character buffer writes with cursor tracking, wrap and offset-based scrolling.
module char_buffer_ctrl #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 24,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic        px_clk,
    input  logic        clr_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd,
    input  logic [7:0]  cmd_data,
    output logic        buf_wen,
    output logic [10:0] buf_addr,
    output logic [7:0]  buf_din,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic [4:0]  first_row
);
    typedef enum logic [2:0] {IDLE, WR, WRS, NL, FILL} state_t;

    state_t      state_q;
    logic        ready_q, wen_q;
    logic [10:0] addr_q, fill_end_q;
    logic [7:0]  din_q;
    logic [4:0]  row_q, first_q;
    logic [6:0]  col_q;

    logic [5:0]  sum;
    logic [4:0]  phys, first_inc;
    logic [10:0] row_base, first_base, cur_addr;
    logic        last_col, last_row;

    always_comb begin
        sum        = {1'b0, first_q} + {1'b0, row_q};
        phys       = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
        row_base   = 11'(phys) * 11'(COLS);
        first_base = 11'(first_q) * 11'(COLS);
        cur_addr   = row_base + 11'(col_q);
        first_inc  = (first_q == 5'(ROWS - 1)) ? 5'd0 : first_q + 5'd1;
        last_col   = col_q == 7'(COLS - 1);
        last_row   = row_q == 5'(ROWS - 1);
    end

    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            fill_end_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            first_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    ready_q <= 1'b0;
                    wen_q   <= 1'b1;
                    din_q   <= FILL_CHAR;
                    case (cmd)
                        2'b00: begin
                            addr_q  <= cur_addr;
                            din_q   <= cmd_data;
                            col_q   <= last_col ? 7'd0 : col_q + 7'd1;
                            row_q   <= (last_col && !last_row) ? row_q + 5'd1 : row_q;
                            first_q <= (last_col && last_row) ? first_inc : first_q;
                            // fill bound of the row being scrolled out, captured before first_row moves
                            fill_end_q <= first_base + 11'(COLS - 1);
                            state_q <= (last_col && last_row) ? WRS : WR;
                        end
                        2'b01: begin
                            addr_q     <= '0;
                            fill_end_q <= 11'(COLS * ROWS - 1);
                            row_q      <= '0;
                            col_q      <= '0;
                            first_q    <= '0;
                            state_q    <= FILL;
                        end
                        2'b10: begin
                            addr_q     <= cur_addr;
                            fill_end_q <= row_base + 11'(COLS - 1);
                            state_q    <= FILL;
                        end
                        default: begin
                            col_q      <= '0;
                            row_q      <= last_row ? row_q : row_q + 5'd1;
                            first_q    <= last_row ? first_inc : first_q;
                            wen_q      <= last_row;
                            addr_q     <= first_base;
                            fill_end_q <= first_base + 11'(COLS - 1);
                            state_q    <= last_row ? FILL : NL;
                        end
                    endcase
                end
                WR, NL: begin
                    wen_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                WRS: begin
                    addr_q  <= fill_end_q - 11'(COLS - 1);
                    din_q   <= FILL_CHAR;
                    state_q <= FILL;
                end
                FILL: begin
                    if (addr_q == fill_end_q) begin
                        wen_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        addr_q <= addr_q + 11'd1;
                    end
                end
                default: begin
                    wen_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign buf_wen    = wen_q;
    assign buf_addr   = addr_q;
    assign buf_din    = din_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign first_row  = first_q;
endmodule
